// File: rtl/note_env_ctrl.sv
// rtl/note_env_ctrl.sv - command-driven attack/sustain/release envelope controller
//
// Purpose: accepts 16-bit command words (note-on/off, attack/release step
// writes) and produces a ticked linear envelope amplitude plus a one-cycle
// gate retrigger pulse for a synth voice.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   cmd_valid    in   command word present on cmd_data
//   cmd_data     in   [15:14] opcode, [13:10] ignored, [9:0] value
//   cmd_ready    out  command can be accepted this cycle
//   gate         out  one-cycle retrigger pulse after a note-on
//   amp_out      out  envelope amplitude
//   env_state    out  IDLE=00 ATTACK=01 SUSTAIN=10 RELEASE=11
//   note_active  out  high in ATTACK or SUSTAIN
module note_env_ctrl #(
  parameter int         CLKSPEED    = 48_000_000,
  parameter int         TICK_HZ     = 48_000,
  parameter logic [9:0] ATTACK_DEF  = 10'd8,
  parameter logic [9:0] RELEASE_DEF = 10'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        gate,
  output logic [9:0]  amp_out,
  output logic [1:0]  env_state,
  output logic        note_active
);

  localparam int TICK_DIV_RAW = CLKSPEED / TICK_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 2) ? 2 : TICK_DIV_RAW;
  localparam int PW           = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] OP_OFF = 2'b00;
  localparam logic [1:0] OP_ON  = 2'b01;
  localparam logic [1:0] OP_ATK = 2'b10;
  localparam logic [1:0] OP_REL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ATTACK  = 2'b01,
    S_SUSTAIN = 2'b10,
    S_RELEASE = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_amp, w_amp_nxt;
  logic [9:0]    r_target, w_target_nxt;
  logic [9:0]    r_att_step, w_att_step_nxt;
  logic [9:0]    r_rel_step, w_rel_step_nxt;
  logic          r_gate, w_gate_nxt;
  logic          r_note_active;
  logic          r_cmd_ready;
  logic [PW-1:0] r_presc;

  logic          w_tick;
  logic          w_accept;
  logic [1:0]    w_op;
  logic [9:0]    w_val;
  logic [10:0]   w_sum;
  logic [3:0]    w_unused_bits;

  assign w_tick        = (r_presc == TICK_LAST);
  assign w_accept      = cmd_valid && r_cmd_ready;
  assign w_op          = cmd_data[15:14];
  assign w_val         = cmd_data[9:0];
  assign w_unused_bits = cmd_data[13:10];
  // One bit wider than the amplitude so a large step cannot wrap past target.
  assign w_sum         = {1'b0, r_amp} + {1'b0, r_att_step};

  // Free-running tick prescaler, independent of command traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Ready drops for exactly the cycle after each acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
    end else begin
      r_cmd_ready <= ~w_accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_amp         <= '0;
      r_target      <= '0;
      r_att_step    <= ATTACK_DEF;
      r_rel_step    <= RELEASE_DEF;
      r_gate        <= 1'b0;
      r_note_active <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_amp         <= w_amp_nxt;
      r_target      <= w_target_nxt;
      r_att_step    <= w_att_step_nxt;
      r_rel_step    <= w_rel_step_nxt;
      r_gate        <= w_gate_nxt;
      r_note_active <= (w_state_nxt == S_ATTACK) || (w_state_nxt == S_SUSTAIN);
    end
  end

  // An accepted command takes priority; a coincident tick is dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_amp_nxt      = r_amp;
    w_target_nxt   = r_target;
    w_att_step_nxt = r_att_step;
    w_rel_step_nxt = r_rel_step;
    w_gate_nxt     = 1'b0;
    if (w_accept) begin
      case (w_op)
        OP_OFF: begin
          if ((r_state == S_ATTACK) || (r_state == S_SUSTAIN)) begin
            w_state_nxt = S_RELEASE;
          end
        end
        OP_ON: begin
          if (w_val == 10'd0) begin
            // Zero-level note-on behaves as note-off.
            if ((r_state == S_ATTACK) || (r_state == S_SUSTAIN)) begin
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_target_nxt = w_val;
            w_gate_nxt   = 1'b1;
            if (w_val > r_amp) begin
              w_state_nxt = S_ATTACK;
            end else begin
              w_amp_nxt   = w_val;
              w_state_nxt = S_SUSTAIN;
            end
          end
        end
        OP_ATK: w_att_step_nxt = w_val;
        OP_REL: w_rel_step_nxt = w_val;
      endcase
    end else if (w_tick) begin
      case (r_state)
        S_ATTACK: begin
          if ((r_att_step == 10'd0) || (w_sum >= {1'b0, r_target})) begin
            w_amp_nxt   = r_target;
            w_state_nxt = S_SUSTAIN;
          end else begin
            w_amp_nxt = w_sum[9:0];
          end
        end
        S_RELEASE: begin
          if ((r_rel_step == 10'd0) || (r_amp <= r_rel_step)) begin
            w_amp_nxt   = 10'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_amp_nxt = r_amp - r_rel_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign gate        = r_gate;
  assign amp_out     = r_amp;
  assign env_state   = r_state;
  assign note_active = r_note_active;

endmodule

// File: tb/tb_note_env_ctrl.sv
// tb/tb_note_env_ctrl.sv - directed self-checking bench for note_env_ctrl with a 4-cycle tick
module tb_note_env_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        gate;
  logic [9:0]  amp_out;
  logic [1:0]  env_state;
  logic        note_active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  note_env_ctrl #(
    .CLKSPEED    (48_000_000),
    .TICK_HZ     (12_000_000),
    .ATTACK_DEF  (10'd8),
    .RELEASE_DEF (10'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .gate        (gate),
    .amp_out     (amp_out),
    .env_state   (env_state),
    .note_active (note_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    int          ncyc;
    int          amp;
    int          st;
    int          g;
    int          r;
    int          a;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_all(input string nm, input int amp, input int st, input int g,
                         input int r, input int a);
    chk({nm, " amp"}, int'(amp_out), amp);
    chk({nm, " state"}, int'(env_state), st);
    chk({nm, " gate"}, int'(gate), g);
    chk({nm, " ready"}, int'(cmd_ready), r);
    chk({nm, " active"}, int'(note_active), a);
  endtask

  // One clock: inputs already set at the negedge, outputs sampled at the next negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Phase of the first posedge of each entry is noted; ticks land on phase 0.
    tv[0]  = '{1'b1, 16'h4000, 1, 0, 0, 0, 0, 0};   // p1 note-on 0 in IDLE: no change
    tv[1]  = '{1'b0, 16'h0000, 3, 0, 0, 0, 1, 0};
    tv[2]  = '{1'b1, 16'h8000, 1, 0, 0, 0, 0, 0};   // p1 attack step 0
    tv[3]  = '{1'b0, 16'h0000, 1, 0, 0, 0, 1, 0};
    tv[4]  = '{1'b1, 16'h4032, 1, 0, 1, 1, 0, 1};   // p3 note-on 50
    tv[5]  = '{1'b0, 16'h0000, 1, 50, 2, 0, 1, 1};  // p0 tick jumps to target
    tv[6]  = '{1'b1, 16'h4000, 1, 50, 3, 0, 0, 0};  // p1 note-on 0 in SUSTAIN
    tv[7]  = '{1'b0, 16'h0000, 3, 46, 3, 0, 1, 0};
    tv[8]  = '{1'b1, 16'hC000, 1, 46, 3, 0, 0, 0};  // p1 release step 0
    tv[9]  = '{1'b0, 16'h0000, 3, 0, 0, 0, 1, 0};   // tick jumps to 0
    tv[10] = '{1'b1, 16'hC004, 1, 0, 0, 0, 0, 0};
    tv[11] = '{1'b0, 16'h0000, 1, 0, 0, 0, 1, 0};
    tv[12] = '{1'b1, 16'h8008, 1, 0, 0, 0, 0, 0};
    tv[13] = '{1'b0, 16'h0000, 1, 0, 0, 0, 1, 0};   // p0 tick ignored in IDLE
    tv[14] = '{1'b1, 16'h7C64, 1, 0, 1, 1, 0, 1};   // p1 note-on 100, bits 13:10 set
    tv[15] = '{1'b0, 16'h0000, 3, 8, 1, 0, 1, 1};
    tv[16] = '{1'b0, 16'h0000, 44, 96, 1, 0, 1, 1};
    tv[17] = '{1'b1, 16'h4032, 1, 50, 2, 1, 0, 1};  // p1 note-on 50 below amp 96
    tv[18] = '{1'b0, 16'h0000, 1, 50, 2, 0, 1, 1};
    tv[19] = '{1'b1, 16'h0000, 1, 50, 3, 0, 0, 0};  // p3 note-off
    tv[20] = '{1'b0, 16'h0000, 1, 46, 3, 0, 1, 0};
    tv[21] = '{1'b0, 16'h0000, 4, 42, 3, 0, 1, 0};
    tv[22] = '{1'b1, 16'h4064, 1, 42, 1, 1, 0, 1};  // p1 re-attack from RELEASE
    tv[23] = '{1'b0, 16'h0000, 3, 50, 1, 0, 1, 1};
    tv[24] = '{1'b1, 16'h0000, 1, 50, 3, 0, 0, 0};
    tv[25] = '{1'b0, 16'h0000, 3, 46, 3, 0, 1, 0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 1, 0);
    rst = 1'b0;
    cyc = 0;

    // Attack ramp 8,16,...,96,100 over ticks 1..13.
    send(16'h4064);
    chk_all("on100", 0, 1, 1, 0, 1);
    for (int k = 1; k <= 13; k++) begin
      do step(); while (cyc % 4 != 0);
      chk($sformatf("atk%0d amp", k), int'(amp_out), (k < 13) ? 8 * k : 100);
      chk($sformatf("atk%0d state", k), int'(env_state), (k < 13) ? 1 : 2);
    end
    chk("atk gate", int'(gate), 0);

    // Release from 100 by 4 reaches 0 on tick 25.
    send(16'h0000);
    chk_all("off", 100, 3, 0, 0, 0);
    for (int j = 1; j <= 25; j++) begin
      do step(); while (cyc % 4 != 0);
      chk($sformatf("rel%0d amp", j), int'(amp_out), 100 - 4 * j);
      chk($sformatf("rel%0d state", j), int'(env_state), (j < 25) ? 3 : 0);
    end
    chk("rel active", int'(note_active), 0);

    for (int i = 0; i < 26; i++) begin
      cmd_valid = tv[i].valid;
      cmd_data  = tv[i].data;
      step();
      cmd_valid = 1'b0;
      for (int n = 1; n < tv[i].ncyc; n++) step();
      chk_all($sformatf("v%0d", i), tv[i].amp, tv[i].st, tv[i].g, tv[i].r, tv[i].a);
    end

    // cmd_valid held 4 cycles, second accept lands on a tick.
    step();
    cmd_valid = 1'b1;
    cmd_data  = 16'h4064;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d ready", i), int'(cmd_ready), (i % 2 == 0) ? 1 : 0);
      step();
      chk($sformatf("hold%0d gate", i), int'(gate), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("hold%0d amp", i), int'(amp_out), 46);
    end
    cmd_valid = 1'b0;
    do step(); while (cyc % 4 != 0);
    chk("hold next tick amp", int'(amp_out), 54);

    // Large attack step clamps at 1023 without wrapping.
    send(16'h803C);
    chk("atk60 ready", int'(cmd_ready), 0);
    step();
    send(16'h43FF);
    chk_all("on1023", 54, 1, 1, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      do step(); while (cyc % 4 != 0);
      chk($sformatf("big%0d amp", k), int'(amp_out), (k < 17) ? 54 + 60 * k : 1023);
    end
    chk("big state", int'(env_state), 2);
    send(16'h0000);
    repeat (3) step();
    chk_all("big rel", 1019, 3, 0, 1, 0);
    send(16'h43FF);
    chk_all("reattack", 1019, 1, 1, 0, 1);
    step();

    // Asynchronous reset mid-ATTACK.
    #2 rst = 1'b1;
    #1 chk_all("async rst", 0, 0, 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    chk_all("rst held", 0, 0, 0, 1, 0);
    rst = 1'b0;
    cyc = 0;
    send(16'h4064);
    chk_all("post rst on", 0, 1, 1, 0, 1);
    repeat (3) step();
    chk_all("post rst tick", 8, 1, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_env_ctrl.md
NOTE_ENV_CTRL -- requirements
Module: note_env_ctrl

Interface
REQ-001 SHALL have parameter CLKSPEED, default 48_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 48_000, envelope update rate; TICK_DIV = CLKSPEED/TICK_HZ, minimum 2.
REQ-003 SHALL have parameter ATTACK_DEF, default 10'd8, reset value of attack step.
REQ-004 SHALL have parameter RELEASE_DEF, default 10'd4, reset value of release step.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command word present on cmd_data.
REQ-008 SHALL have port cmd_data, input, 16 bits: [15:14] opcode, [9:0] value, [13:10] ignored.
REQ-009 SHALL have port cmd_ready, output, 1 bit: block can accept a command this cycle.
REQ-010 SHALL have port gate, output, 1 bit: one-cycle retrigger pulse to the synth gate input.
REQ-011 SHALL have port amp_out, output, 10 bits: envelope amplitude to the synth amp_in.
REQ-012 SHALL have port env_state, output, 2 bits: IDLE=00, ATTACK=01, SUSTAIN=10, RELEASE=11.
REQ-013 SHALL have port note_active, output, 1 bit: high in ATTACK or SUSTAIN (drives the status LED).

Function
REQ-014 SHALL accept a command on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL go low for exactly the cycle after each acceptance, then return high.
REQ-015 SHALL decode opcodes: 00 note-off, 01 note-on (value = target level), 10 set attack_step = value, 11 set release_step = value.
REQ-016 SHALL treat note-on with value 0 exactly as note-off.
REQ-017 Note-on (value>0), any state: target <= value, gate high for the next cycle only; if value > amp_out, state <= ATTACK; otherwise amp_out <= value and state <= SUSTAIN in the same update.
REQ-018 Note-off: ATTACK or SUSTAIN -> RELEASE; IDLE and RELEASE unchanged; no gate pulse.
REQ-019 Set-rate commands SHALL change only the step register; state and amp_out unchanged; the new step applies from the next tick.
REQ-020 SHALL run a free-running prescaler 0..TICK_DIV-1; tick is asserted for one cycle when count == TICK_DIV-1, after which the count wraps to 0.
REQ-021 ATTACK, on tick: amp_out <= min(amp_out + attack_step, target), computed 11 bits wide, no wrap; on reaching target -> SUSTAIN; attack_step 0 SHALL jump to target.
REQ-022 SUSTAIN: amp_out holds target; ticks ignored.
REQ-023 RELEASE, on tick: amp_out <= max(amp_out - release_step, 0), no underflow; on reaching 0 -> IDLE; release_step 0 SHALL jump to 0.
REQ-024 IDLE: amp_out = 0; ticks ignored.
REQ-025 Command acceptance and tick in the same cycle: the command takes effect and that tick's envelope step SHALL be skipped; the prescaler still wraps.
REQ-026 All outputs SHALL be registered; command effects SHALL be visible one cycle after acceptance.

Reset
REQ-027 On rst high, SHALL immediately force: state IDLE, amp_out 0, target 0, gate 0, note_active 0, cmd_ready 1, prescaler 0, attack_step ATTACK_DEF, release_step RELEASE_DEF.
REQ-028 Reset during any envelope phase SHALL abort it with no gate pulse; the first command after deassertion SHALL be accepted normally.

Verification (TICK_DIV=4 bench)
REQ-029 Note-on 0x4064 (value 100), attack_step 8 -> gate one cycle; amp 8,16,...,96,100 at ticks 1..13; SUSTAIN at 100.
REQ-030 Note-off 0x0000 in SUSTAIN at 100, release_step 4 -> RELEASE; amp reaches 0 after 25 ticks; IDLE; note_active 0.
REQ-031 Note-on 0x4000 (value 0) in SUSTAIN -> RELEASE, no gate pulse; same case from IDLE -> no change.
REQ-032 Note-on 0x4032 (value 50) while in ATTACK at 96 -> amp 50 next cycle, SUSTAIN, gate pulse.
REQ-033 cmd_valid held high 4 cycles -> exactly 2 accepts; cmd_ready pattern 1,0,1,0; accept coincident with tick -> no amp step that tick.
REQ-034 0x803C (attack 60) then note-on 1023; rst pulse mid-ATTACK -> amp 0, IDLE, attack_step back to 8 immediately.
